cache_mem_arbiter: RTL and testbench

//  Shares the single physical-memory (pmem) line port between the instruction cache (IF stage fetch path)
//  and the data cache (MEM stage). Grants one cache-line transaction at a time, steers address/data/controls,
//  and returns the response only to the granted requester. It sits between the two L1 caches and pmem/L2.

---
 rtl/rv32i_types.sv | 18 +
 rtl/cache_mem_arbiter_sva.sv | 54 +++++
 rtl/cache_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types
//   Shared types for the memory-side blocks of the core.
//   cache_line_t : one full cache line as moved between the L1 caches and pmem/L2.
//   arb_state_t  : state encoding of the cache/pmem arbiter.
package rv32i_types;

  localparam int CACHE_LINE_W = 256;

  typedef logic [CACHE_LINE_W-1:0] cache_line_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_sva.sv
// cache_mem_arbiter_sva
//   Protocol checks for cache_mem_arbiter, attached to every instance through bind.
//   - never both pmem commands at once
//   - never both cache responses at once
//   - pmem address held while a command waits for its response
//   - D-cache never raises read and write together
//
// Ports
//   clk, rst                         clock and asynchronous active-low reset of the arbiter
//   pmem_read, pmem_write            pmem command outputs
//   pmem_address, pmem_resp          pmem address output and completion strobe
//   i_resp, d_resp                   cache response strobes
//   d_read, d_write                  D-cache request inputs
module cache_mem_arbiter_sva #(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              pmem_read,
  input logic              pmem_write,
  input logic [ADDR_W-1:0] pmem_address,
  input logic              pmem_resp,
  input logic              i_resp,
  input logic              d_resp,
  input logic              d_read,
  input logic              d_write
);

  a_cmd_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({pmem_read, pmem_write}));

  a_resp_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(i_resp && d_resp));

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    ((pmem_read || pmem_write) && !pmem_resp) |=> $stable(pmem_address));

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(d_read && d_write));

endmodule

bind cache_mem_arbiter cache_mem_arbiter_sva #(.ADDR_W(ADDR_W)) u_sva (
  .clk          (clk),
  .rst          (rst),
  .pmem_read    (pmem_read),
  .pmem_write   (pmem_write),
  .pmem_address (pmem_address),
  .pmem_resp    (pmem_resp),
  .i_resp       (i_resp),
  .d_resp       (d_resp),
  .d_read       (d_read),
  .d_write      (d_write)
);

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single pmem line port between the I-cache (fetch path) and the D-cache.
//   One line transaction is granted at a time. The D side wins contention unless the fairness
//   flag says the I side was passed over last time. Each transaction is followed by a
//   one-cycle RELEASE gap so the requester can drop or change its level request.
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   i_read, i_address           I-cache line read request / address (held until i_resp)
//   i_rdata, i_resp             line data and one-cycle completion strobe to the I-cache
//   d_read, d_write, d_address  D-cache fill / write-back request and address (held until d_resp)
//   d_wdata                     write-back line data
//   d_rdata, d_resp             line data and one-cycle completion strobe to the D-cache
//   pmem_read, pmem_write       pmem command, held until pmem_resp
//   pmem_address, pmem_wdata    pmem line address and write data (driven only from latches)
//   pmem_rdata, pmem_resp       pmem read data and completion strobe
module cache_mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state;
  arb_state_t        state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              fair_flag;

  logic              d_req;

  // A D request is either a fill or a write-back; both together is treated as a write.
  assign d_req = d_read | d_write;

  // Grant decision from IDLE: 1 selects the I side, 0 the D side.
  // Only meaningful when at least one side is requesting.
  function automatic logic grant_i(input logic i_req, input logic dq, input logic flag);
    return i_req && (!dq || ((FAIR != 0) && flag));
  endfunction

  // State, request latches and fairness flag. The winner's address/data/op are captured on
  // the IDLE->SERVE edge so pmem sees stable values regardless of what the caches do next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      fair_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == SERVE_D) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        write_q <= d_write;
        if (i_read) begin
          fair_flag <= 1'b1;
        end
      end else if (state == IDLE && state_next == SERVE_I) begin
        addr_q    <= i_address;
        wdata_q   <= '0;
        write_q   <= 1'b0;
        fair_flag <= 1'b0;
      end
    end
  end

  // Next-state and output steering. Outputs are a pure decode of the state and latches, so
  // an asynchronous reset drops the pmem command in the same cycle. The response strobe is
  // the only combinational path from pmem_resp, and it is qualified by the serving state so
  // stray strobes in IDLE/RELEASE are ignored.
  always_comb begin
    state_next   = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;

    case (state)
      IDLE: begin
        if (i_read || d_req) begin
          state_next = grant_i(i_read, d_req, fair_flag) ? SERVE_I : SERVE_D;
        end
      end

      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        if (pmem_resp) begin
          i_resp     = 1'b1;
          state_next = RELEASE;
        end
      end

      SERVE_D: begin
        pmem_read    = !write_q;
        pmem_write   = write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        if (pmem_resp) begin
          d_resp     = 1'b1;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Self-checking bench for cache_mem_arbiter. One instance with FAIR=1 (dut) and one with
//   FAIR=0 (dut_nf) share all inputs. A vector table covers reset, a lone fetch, stray pmem
//   strobes, write-back then fill; hand-written sequences cover contention ordering and a
//   reset in the middle of a transaction.
module tb_cache_mem_arbiter;
  import rv32i_types::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic [LINE_W-1:0] i_rdata,  d_rdata,  pmem_wdata;
  logic              i_resp,   d_resp,   pmem_read,  pmem_write;
  logic [ADDR_W-1:0] pmem_address;

  logic [LINE_W-1:0] nf_i_rdata, nf_d_rdata, nf_pmem_wdata;
  logic              nf_i_resp,  nf_d_resp,  nf_pmem_read, nf_pmem_write;
  logic [ADDR_W-1:0] nf_pmem_address;

  int tests_run;
  int tests_failed;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .FAIR(0)) dut_nf (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(nf_i_rdata), .i_resp(nf_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(nf_d_rdata), .d_resp(nf_d_resp),
    .pmem_read(nf_pmem_read), .pmem_write(nf_pmem_write), .pmem_address(nf_pmem_address),
    .pmem_wdata(nf_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    cache_line_t       d_wdata;
    logic              pmem_resp;
    cache_line_t       pmem_rdata;
    logic              e_pread;
    logic              e_pwrite;
    logic [ADDR_W-1:0] e_paddr;
    cache_line_t       e_pwdata;
    logic              e_iresp;
    logic              e_dresp;
  } vec_t;

  vec_t vecs[$];

  localparam cache_line_t Z  = '0;
  localparam cache_line_t A5 = {32{8'hA5}};
  localparam cache_line_t W1 = {8{32'h1234_5678}};
  localparam cache_line_t R2 = {8{32'hCAFE_F00D}};

  function automatic vec_t mk(
    input logic rst_v, input logic ir, input logic [ADDR_W-1:0] ia,
    input logic dr, input logic dw, input logic [ADDR_W-1:0] da, input cache_line_t dwd,
    input logic pr, input cache_line_t prd,
    input logic epr, input logic epw, input logic [ADDR_W-1:0] epa, input cache_line_t epwd,
    input logic eir, input logic edr);
    vec_t v;
    v.rst = rst_v;  v.i_read = ir;  v.i_address = ia;
    v.d_read = dr;  v.d_write = dw; v.d_address = da; v.d_wdata = dwd;
    v.pmem_resp = pr; v.pmem_rdata = prd;
    v.e_pread = epr; v.e_pwrite = epw; v.e_paddr = epa; v.e_pwdata = epwd;
    v.e_iresp = eir; v.e_dresp = edr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic toEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic toSample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    toEdge();
    rst        = v.rst;
    i_read     = v.i_read;
    i_address  = v.i_address;
    d_read     = v.d_read;
    d_write    = v.d_write;
    d_address  = v.d_address;
    d_wdata    = v.d_wdata;
    pmem_resp  = v.pmem_resp;
    pmem_rdata = v.pmem_rdata;
    toSample();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    #2 rst = 1'b0;

    // Reset with both requests, release, D fill with stray strobes afterwards
    vecs.push_back(mk(0,1,32'h40,1,0,32'h100,Z, 0,Z,  0,0,32'h0,  Z, 0,0));
    vecs.push_back(mk(0,1,32'h40,1,0,32'h100,Z, 0,Z,  0,0,32'h0,  Z, 0,0));
    vecs.push_back(mk(1,1,32'h40,1,0,32'h100,Z, 0,Z,  0,0,32'h0,  Z, 0,0));
    vecs.push_back(mk(1,0,32'h40,1,0,32'h100,Z, 1,R2, 1,0,32'h100,Z, 0,1));
    vecs.push_back(mk(1,0,32'h40,0,0,32'h100,Z, 1,R2, 0,0,32'h0,  Z, 0,0));
    vecs.push_back(mk(1,0,32'h40,0,0,32'h100,Z, 1,A5, 0,0,32'h0,  Z, 0,0));
    // Lone I fetch, pmem answers after 5 waiting cycles
    vecs.push_back(mk(1,1,32'h40,0,0,32'h0,Z,   0,Z,  0,0,32'h0,  Z, 0,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,1,32'h40,0,0,32'h0,Z, 0,Z,  1,0,32'h40, Z, 0,0));
    vecs.push_back(mk(1,1,32'h40,0,0,32'h0,Z,   1,A5, 1,0,32'h40, Z, 1,0));
    vecs.push_back(mk(1,0,32'h40,0,0,32'h0,Z,   0,Z,  0,0,32'h0,  Z, 0,0));
    // Write-back then fill; I address wiggles during SERVE_D
    vecs.push_back(mk(1,0,32'h0,0,1,32'h300,W1,   0,Z,  0,0,32'h0,  Z,  0,0));
    vecs.push_back(mk(1,1,32'h500,0,1,32'h300,W1, 0,Z,  0,1,32'h300,W1, 0,0));
    vecs.push_back(mk(1,0,32'h500,0,1,32'h300,W1, 1,Z,  0,1,32'h300,W1, 0,1));
    vecs.push_back(mk(1,0,32'h0,1,0,32'h400,Z,    0,Z,  0,0,32'h0,  Z,  0,0));
    vecs.push_back(mk(1,0,32'h0,1,0,32'h400,Z,    0,Z,  0,0,32'h0,  Z,  0,0));
    vecs.push_back(mk(1,0,32'h0,1,0,32'h400,Z,    1,R2, 1,0,32'h400,Z,  0,1));
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,Z,      0,Z,  0,0,32'h0,  Z,  0,0));
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,Z,      0,Z,  0,0,32'h0,  Z,  0,0));

    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      checkOutput($sformatf("v%0d pmem_read", n),    LINE_W'(pmem_read),    LINE_W'(vecs[n].e_pread));
      checkOutput($sformatf("v%0d pmem_write", n),   LINE_W'(pmem_write),   LINE_W'(vecs[n].e_pwrite));
      checkOutput($sformatf("v%0d pmem_address", n), LINE_W'(pmem_address), LINE_W'(vecs[n].e_paddr));
      checkOutput($sformatf("v%0d pmem_wdata", n),   pmem_wdata,            vecs[n].e_pwdata);
      checkOutput($sformatf("v%0d i_resp", n),       LINE_W'(i_resp),       LINE_W'(vecs[n].e_iresp));
      checkOutput($sformatf("v%0d d_resp", n),       LINE_W'(d_resp),       LINE_W'(vecs[n].e_dresp));
      if (vecs[n].e_iresp) checkOutput($sformatf("v%0d i_rdata", n), i_rdata, vecs[n].pmem_rdata);
      if (vecs[n].e_dresp) checkOutput($sformatf("v%0d d_rdata", n), d_rdata, vecs[n].pmem_rdata);
    end

    // Contention with both requests held: FAIR=1 alternates D,I,D,I; FAIR=0 stays on D
    toEdge();
    rst = 1'b0; i_read = 1'b1; i_address = 32'h200; d_read = 1'b1; d_write = 1'b0;
    d_address = 32'h100; d_wdata = '0; pmem_resp = 1'b0;
    toSample();
    toEdge(); rst = 1'b1; toSample();
    for (int g = 0; g < 4; g++) begin
      toEdge(); pmem_resp = 1'b1; pmem_rdata = R2; toSample();
      checkOutput($sformatf("fair g%0d pmem_read", g), LINE_W'(pmem_read), LINE_W'(1'b1));
      checkOutput($sformatf("fair g%0d pmem_address", g), LINE_W'(pmem_address),
                  LINE_W'((g % 2 == 0) ? 32'h100 : 32'h200));
      checkOutput($sformatf("fair g%0d i_resp", g), LINE_W'(i_resp), LINE_W'(g % 2 == 1));
      checkOutput($sformatf("fair g%0d d_resp", g), LINE_W'(d_resp), LINE_W'(g % 2 == 0));
      checkOutput($sformatf("nofair g%0d pmem_address", g), LINE_W'(nf_pmem_address), LINE_W'(32'h100));
      checkOutput($sformatf("nofair g%0d i_resp", g), LINE_W'(nf_i_resp), LINE_W'(1'b0));
      checkOutput($sformatf("nofair g%0d d_resp", g), LINE_W'(nf_d_resp), LINE_W'(1'b1));
      toEdge(); pmem_resp = 1'b0; toSample();
      checkOutput($sformatf("fair g%0d release pmem_read", g), LINE_W'(pmem_read), LINE_W'(1'b0));
      toEdge(); toSample();
      checkOutput($sformatf("fair g%0d idle pmem_read", g), LINE_W'(pmem_read), LINE_W'(1'b0));
    end

    // Reset dropped in the middle of an I fetch
    toEdge(); rst = 1'b0; i_read = 1'b0; d_read = 1'b0; pmem_resp = 1'b0; toSample();
    toEdge(); rst = 1'b1; i_read = 1'b1; i_address = 32'h40; toSample();
    checkOutput("midrst idle pmem_read", LINE_W'(pmem_read), LINE_W'(1'b0));
    toEdge(); toSample();
    checkOutput("midrst serve pmem_read", LINE_W'(pmem_read), LINE_W'(1'b1));
    toEdge(); rst = 1'b0; #1;
    checkOutput("midrst async pmem_read", LINE_W'(pmem_read), LINE_W'(1'b0));
    checkOutput("midrst async pmem_address", LINE_W'(pmem_address), LINE_W'(32'h0));
    pmem_resp = 1'b1; pmem_rdata = A5;
    toSample();
    checkOutput("midrst i_resp", LINE_W'(i_resp), LINE_W'(1'b0));
    toEdge(); rst = 1'b1; i_read = 1'b0; pmem_resp = 1'b0; toSample();
    checkOutput("postrst idle pmem_read", LINE_W'(pmem_read), LINE_W'(1'b0));
    checkOutput("postrst i_resp", LINE_W'(i_resp), LINE_W'(1'b0));
    toEdge(); i_read = 1'b1; toSample();
    checkOutput("postrst still idle", LINE_W'(pmem_read), LINE_W'(1'b0));
    toEdge(); toSample();
    checkOutput("postrst new fetch pmem_read", LINE_W'(pmem_read), LINE_W'(1'b1));
    checkOutput("postrst new fetch address", LINE_W'(pmem_address), LINE_W'(32'h40));
    toEdge(); pmem_resp = 1'b1; toSample();
    checkOutput("postrst new fetch i_resp", LINE_W'(i_resp), LINE_W'(1'b1));
    checkOutput("postrst new fetch i_rdata", i_rdata, A5);
    toEdge(); i_read = 1'b0; pmem_resp = 1'b0; toSample();
    toEdge();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
